// File: rtl/lb_fill_scheduler_pkg.sv
// Shared sizes, constants and state encoding for the line-buffer fill scheduler.
// Imported by the interface, the row tracker and the top.
package lb_fill_scheduler_pkg;
  localparam int LB_LINES   = 62;
  localparam int LB_BANK_BW = 6;
  localparam int TO_BW      = 12;
  localparam int H_SIZE_BW  = 11;
  localparam int V_SIZE_BW  = 11;

  localparam logic [LB_BANK_BW-1:0] LB_LAST_BANK = LB_BANK_BW'(LB_LINES - 1);
  localparam logic [LB_BANK_BW-1:0] LB_LINES_B   = LB_BANK_BW'(LB_LINES);
  localparam logic [LB_BANK_BW-1:0] B_ONE        = LB_BANK_BW'(1);
  localparam logic [V_SIZE_BW-1:0]  LB_LINES_V   = V_SIZE_BW'(LB_LINES);
  localparam logic [H_SIZE_BW-1:0]  H_ONE        = H_SIZE_BW'(1);
  localparam logic [V_SIZE_BW-1:0]  V_ONE        = V_SIZE_BW'(1);

  typedef enum logic [1:0] {LBS_IDLE, LBS_FILL, LBS_RUN, LBS_DONE} lb_sched_state_e;
endpackage

// File: rtl/lb_fill_scheduler_if.sv
// Read-request handshake plus the write and read issue ports of the line buffer.
// Handshake: a read transfers on a cycle where i_rd_valid && o_rd_ready; x/y must stay stable while stalled.
interface lb_fill_scheduler_if
  import lb_fill_scheduler_pkg::*;
;
  logic                  i_rd_valid;
  logic [H_SIZE_BW-1:0]  i_rd_x;
  logic [V_SIZE_BW-1:0]  i_rd_y;
  logic                  o_rd_ready;
  logic                  o_wr_en;
  logic [LB_BANK_BW-1:0] o_wr_bank;
  logic [H_SIZE_BW-1:0]  o_wr_addr;
  logic                  o_lb_valid;
  logic [LB_BANK_BW-1:0] o_lb_bank;
  logic [H_SIZE_BW-1:0]  o_lb_addr;
  logic                  o_lb_miss;

  modport master (
    output i_rd_valid, i_rd_x, i_rd_y,
    input  o_rd_ready, o_wr_en, o_wr_bank, o_wr_addr,
    input  o_lb_valid, o_lb_bank, o_lb_addr, o_lb_miss
  );

  modport slave (
    input  i_rd_valid, i_rd_x, i_rd_y,
    output o_rd_ready, o_wr_en, o_wr_bank, o_wr_addr,
    output o_lb_valid, o_lb_bank, o_lb_addr, o_lb_miss
  );
endinterface

// File: rtl/lb_fill_scheduler_row_tracker.sv
// Frame1 write-side bookkeeping: column, completed rows and current bank, plus the registered write port.
// A frame start restarts the counters in the same cycle so a coincident pixel lands at row 0 col 0.
module lb_row_tracker
  import lb_fill_scheduler_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_active,
  input  logic                  i_wr_valid,
  input  logic [H_SIZE_BW-1:0]  i_hsize,
  input  logic [V_SIZE_BW-1:0]  i_vsize,
  output logic [V_SIZE_BW-1:0]  o_rows_done,
  output logic [LB_BANK_BW-1:0] o_cur_bank,
  output logic                  o_wr_en,
  output logic [LB_BANK_BW-1:0] o_wr_bank,
  output logic [H_SIZE_BW-1:0]  o_wr_addr
);
  logic [H_SIZE_BW-1:0]  r_wr_x, w_base_x, w_x_nxt;
  logic [V_SIZE_BW-1:0]  r_rows_done, w_base_rows, w_rows_nxt;
  logic [LB_BANK_BW-1:0] r_wr_bank, w_base_bank, w_bank_nxt;
  logic                  r_wr_en;
  logic [LB_BANK_BW-1:0] r_wr_bank_o;
  logic [H_SIZE_BW-1:0]  r_wr_addr;
  logic                  w_wr_act;

  always_comb begin
    w_base_x    = i_frame_start ? '0 : r_wr_x;
    w_base_rows = i_frame_start ? '0 : r_rows_done;
    w_base_bank = i_frame_start ? '0 : r_wr_bank;
    // Pixels past the last frame row are dropped rather than overwriting resident rows
    w_wr_act    = i_wr_valid && (i_frame_start || i_active) && (w_base_rows < i_vsize);
    w_x_nxt     = w_base_x;
    w_rows_nxt  = w_base_rows;
    w_bank_nxt  = w_base_bank;
    if (w_wr_act) begin
      if (w_base_x == i_hsize - H_ONE) begin
        w_x_nxt    = '0;
        w_rows_nxt = w_base_rows + V_ONE;
        w_bank_nxt = (w_base_bank == LB_LAST_BANK) ? '0 : w_base_bank + B_ONE;
      end else begin
        w_x_nxt = w_base_x + H_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_x      <= '0;
      r_rows_done <= '0;
      r_wr_bank   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_bank_o <= '0;
      r_wr_addr   <= '0;
    end else begin
      r_wr_x      <= w_x_nxt;
      r_rows_done <= w_rows_nxt;
      r_wr_bank   <= w_bank_nxt;
      r_wr_en     <= w_wr_act;
      if (w_wr_act) begin
        r_wr_bank_o <= w_base_bank;
        r_wr_addr   <= w_base_x;
      end
    end
  end

  assign o_rows_done = r_rows_done;
  assign o_cur_bank  = r_wr_bank;
  assign o_wr_en     = r_wr_en;
  assign o_wr_bank   = r_wr_bank_o;
  assign o_wr_addr   = r_wr_addr;
endmodule

// File: rtl/lb_fill_scheduler.sv
// Line-buffer fill scheduler: frame FSM, read classifier, bank arithmetic and stall timeout.
// Optional LB_SCHED_STAT_EN adds saturating stall/miss statistics outputs.
module lb_fill_scheduler
  import lb_fill_scheduler_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_frame_end,
  input  logic                  i_wr_valid,
  input  logic [H_SIZE_BW-1:0]  r_hsize,
  input  logic [V_SIZE_BW-1:0]  r_vsize,
  input  logic [5:0]            r_prefill,
  input  logic [TO_BW-1:0]      r_timeout,
  lb_fill_scheduler_if.slave    bus,
  output logic                  o_busy,
  output lb_sched_state_e       o_dbg_state
`ifdef LB_SCHED_STAT_EN
  ,
  output logic [31:0]           o_stat_stall,
  output logic [31:0]           o_stat_miss
`endif
);
  lb_sched_state_e       r_state, w_state_nxt;
  logic [V_SIZE_BW-1:0]  w_rows_done, w_diff;
  logic [LB_BANK_BW-1:0] w_cur_bank, w_rd_bank;
  logic [LB_BANK_BW:0]   w_bank_raw;
  logic [TO_BW-1:0]      r_stall_cnt;
  logic                  w_rd_phase, w_oor, w_pending, w_evict, w_to_hit;
  logic                  w_ready, w_miss, w_accept, w_stall;
  logic                  r_lb_valid, r_lb_miss;
  logic [LB_BANK_BW-1:0] r_lb_bank;
  logic [H_SIZE_BW-1:0]  r_lb_addr;

  lb_row_tracker u_row_tracker (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_active      (r_state != LBS_IDLE),
    .i_wr_valid    (i_wr_valid),
    .i_hsize       (r_hsize),
    .i_vsize       (r_vsize),
    .o_rows_done   (w_rows_done),
    .o_cur_bank    (w_cur_bank),
    .o_wr_en       (bus.o_wr_en),
    .o_wr_bank     (bus.o_wr_bank),
    .o_wr_addr     (bus.o_wr_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= LBS_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LBS_IDLE: w_state_nxt = LBS_IDLE;
      LBS_FILL: if (w_rows_done >= {{(V_SIZE_BW-6){1'b0}}, r_prefill}) w_state_nxt = LBS_RUN;
      LBS_RUN:  if (w_rows_done == r_vsize) w_state_nxt = LBS_DONE;
      LBS_DONE: if (i_frame_end) w_state_nxt = LBS_IDLE;
      default:  w_state_nxt = LBS_IDLE;
    endcase
    if (i_frame_start) w_state_nxt = LBS_FILL;
  end

  // Classification uses the registered row count, so a row finishing this cycle is visible next cycle
  always_comb begin
    w_rd_phase = (r_state == LBS_RUN) || (r_state == LBS_DONE);
    w_oor      = (bus.i_rd_x >= r_hsize) || (bus.i_rd_y >= r_vsize);
    w_pending  = bus.i_rd_y >= w_rows_done;
    w_diff     = w_rows_done - bus.i_rd_y;
    w_evict    = w_diff > LB_LINES_V;
    w_to_hit   = (r_timeout != '0) && (r_stall_cnt >= r_timeout);
    w_ready    = w_rd_phase && (w_oor || w_to_hit || !w_pending);
    w_miss     = w_oor || w_pending || w_evict;
    w_accept   = bus.i_rd_valid && w_ready;
    w_stall    = bus.i_rd_valid && !w_ready && (r_state == LBS_RUN);
    // Resident rows sit 1..LB_LINES behind the write bank; one wrap correction suffices
    w_bank_raw = {1'b0, w_cur_bank} - w_diff[LB_BANK_BW:0];
    w_rd_bank  = w_bank_raw[LB_BANK_BW] ? (w_bank_raw[LB_BANK_BW-1:0] + LB_LINES_B)
                                        : w_bank_raw[LB_BANK_BW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_lb_valid  <= 1'b0;
      r_lb_miss   <= 1'b0;
      r_lb_bank   <= '0;
      r_lb_addr   <= '0;
    end else begin
      if (i_frame_start || w_accept)            r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      r_lb_valid <= w_accept;
      if (w_accept) begin
        r_lb_miss <= w_miss;
        r_lb_bank <= w_miss ? '0 : w_rd_bank;
        r_lb_addr <= bus.i_rd_x;
      end
    end
  end

`ifdef LB_SCHED_STAT_EN
  logic [31:0] r_stat_stall, r_stat_miss;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_frame_start) begin
      r_stat_stall <= '0;
      r_stat_miss  <= '0;
    end else begin
      if (w_stall && (r_stat_stall != '1))             r_stat_stall <= r_stat_stall + 32'd1;
      if (w_accept && w_miss && (r_stat_miss != '1))   r_stat_miss  <= r_stat_miss + 32'd1;
    end
  end

  assign o_stat_stall = r_stat_stall;
  assign o_stat_miss  = r_stat_miss;
`endif

  assign bus.o_rd_ready = w_ready;
  assign bus.o_lb_valid = r_lb_valid;
  assign bus.o_lb_miss  = r_lb_miss;
  assign bus.o_lb_bank  = r_lb_bank;
  assign bus.o_lb_addr  = r_lb_addr;
  assign o_busy         = (r_state != LBS_IDLE);
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_lb_fill_scheduler.sv
// Directed bench for lb_fill_scheduler: fill/stream sequences, read-classification tables,
// stall timeout and mid-frame reset.
module tb_lb_fill_scheduler;
  import lb_fill_scheduler_pkg::*;

  typedef struct {
    logic [H_SIZE_BW-1:0]  x;
    logic [V_SIZE_BW-1:0]  y;
    logic                  exp_ready;
    logic                  exp_miss;
    logic [LB_BANK_BW-1:0] exp_bank;
  } rd_vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 i_rst = 1'b1;
  logic                 i_frame_start = 1'b0;
  logic                 i_frame_end = 1'b0;
  logic                 i_wr_valid = 1'b0;
  logic [H_SIZE_BW-1:0] r_hsize = '0;
  logic [V_SIZE_BW-1:0] r_vsize = '0;
  logic [5:0]           r_prefill = '0;
  logic [TO_BW-1:0]     r_timeout = '0;
  logic                 o_busy;
  lb_sched_state_e      o_dbg_state;
`ifdef LB_SCHED_STAT_EN
  logic [31:0]          o_stat_stall, o_stat_miss;
`endif

  lb_fill_scheduler_if bus();

  lb_fill_scheduler dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_frame_end   (i_frame_end),
    .i_wr_valid    (i_wr_valid),
    .r_hsize       (r_hsize),
    .r_vsize       (r_vsize),
    .r_prefill     (r_prefill),
    .r_timeout     (r_timeout),
    .bus           (bus),
    .o_busy        (o_busy),
    .o_dbg_state   (o_dbg_state)
`ifdef LB_SCHED_STAT_EN
    ,
    .o_stat_stall  (o_stat_stall),
    .o_stat_miss   (o_stat_miss)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic init_frame(input int hs, input int vs, input int pf, input int to);
    r_hsize       = H_SIZE_BW'(hs);
    r_vsize       = V_SIZE_BW'(vs);
    r_prefill     = 6'(pf);
    r_timeout     = TO_BW'(to);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic stream(input int n_pix, input int first_pix, input int hs, input bit chk_rdy_low);
    for (int k = 0; k < n_pix; k++) begin
      i_wr_valid = 1'b1;
      #1;
      if (chk_rdy_low) check($sformatf("fill_ready_p%0d", first_pix + k), 32'(bus.o_rd_ready), 32'd0);
      tick();
      check($sformatf("wr_en_p%0d", first_pix + k), 32'(bus.o_wr_en), 32'd1);
      check($sformatf("wr_bank_p%0d", first_pix + k), 32'(bus.o_wr_bank), ((first_pix + k) / hs) % 62);
      check($sformatf("wr_addr_p%0d", first_pix + k), 32'(bus.o_wr_addr), (first_pix + k) % hs);
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic apply_vec(input string tag, input rd_vec_t v);
    bus.i_rd_valid = 1'b1;
    bus.i_rd_x     = v.x;
    bus.i_rd_y     = v.y;
    #1;
    check({tag, "_ready"}, 32'(bus.o_rd_ready), 32'(v.exp_ready));
    tick();
    bus.i_rd_valid = 1'b0;
    check({tag, "_lb_valid"}, 32'(bus.o_lb_valid), 32'(v.exp_ready));
    if (v.exp_ready) begin
      check({tag, "_lb_miss"}, 32'(bus.o_lb_miss), 32'(v.exp_miss));
      check({tag, "_lb_addr"}, 32'(bus.o_lb_addr), 32'(v.x));
      if (!v.exp_miss) check({tag, "_lb_bank"}, 32'(bus.o_lb_bank), 32'(v.exp_bank));
    end
  endtask

  rd_vec_t vec_a[7];
  rd_vec_t vec_b[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rows_done=3, write bank=3, vsize=8, hsize=4
    vec_a[0] = '{x: 11'd0, y: 11'd0, exp_ready: 1'b1, exp_miss: 1'b0, exp_bank: 6'd0};
    vec_a[1] = '{x: 11'd3, y: 11'd2, exp_ready: 1'b1, exp_miss: 1'b0, exp_bank: 6'd2};
    vec_a[2] = '{x: 11'd2, y: 11'd1, exp_ready: 1'b1, exp_miss: 1'b0, exp_bank: 6'd1};
    vec_a[3] = '{x: 11'd1, y: 11'd3, exp_ready: 1'b0, exp_miss: 1'b0, exp_bank: 6'd0};
    vec_a[4] = '{x: 11'd0, y: 11'd9, exp_ready: 1'b1, exp_miss: 1'b1, exp_bank: 6'd0};
    vec_a[5] = '{x: 11'd4, y: 11'd0, exp_ready: 1'b1, exp_miss: 1'b1, exp_bank: 6'd0};
    vec_a[6] = '{x: 11'd0, y: 11'd7, exp_ready: 1'b0, exp_miss: 1'b0, exp_bank: 6'd0};
    // rows_done=70, write bank=8, vsize=70, hsize=4
    vec_b[0] = '{x: 11'd0, y: 11'd5,  exp_ready: 1'b1, exp_miss: 1'b1, exp_bank: 6'd0};
    vec_b[1] = '{x: 11'd2, y: 11'd8,  exp_ready: 1'b1, exp_miss: 1'b0, exp_bank: 6'd8};
    vec_b[2] = '{x: 11'd3, y: 11'd69, exp_ready: 1'b1, exp_miss: 1'b0, exp_bank: 6'd7};
    vec_b[3] = '{x: 11'd1, y: 11'd7,  exp_ready: 1'b1, exp_miss: 1'b1, exp_bank: 6'd0};
    vec_b[4] = '{x: 11'd1, y: 11'd30, exp_ready: 1'b1, exp_miss: 1'b0, exp_bank: 6'd30};
    vec_b[5] = '{x: 11'd0, y: 11'd70, exp_ready: 1'b1, exp_miss: 1'b1, exp_bank: 6'd0};

    bus.i_rd_valid = 1'b0;
    bus.i_rd_x     = '0;
    bus.i_rd_y     = '0;

    // reset state
    repeat (3) tick();
    i_rst = 1'b0;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(LBS_IDLE));
    check("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("rst_lb_valid", 32'(bus.o_lb_valid), 32'd0);
    check("rst_rd_ready", 32'(bus.o_rd_ready), 32'd0);
    check("rst_lb_miss", 32'(bus.o_lb_miss), 32'd0);

    // writes ignored while idle
    i_wr_valid = 1'b1;
    tick();
    i_wr_valid = 1'b0;
    check("idle_wr_drop", 32'(bus.o_wr_en), 32'd0);

    // frame A: 4x8, prefill 2; no reads accepted until the 8th pixel is written
    init_frame(4, 8, 2, 0);
    check("fill_state", 32'(o_dbg_state), 32'(LBS_FILL));
    check("fill_busy", 32'(o_busy), 32'd1);
    stream(8, 0, 4, 1'b1);
    stream(4, 8, 4, 1'b0);
    check("run_state", 32'(o_dbg_state), 32'(LBS_RUN));
    #1;
    check("run_ready_y0", 32'(bus.o_rd_ready), 32'd1);

    for (int i = 0; i < 7; i++) apply_vec($sformatf("vecA%0d", i), vec_a[i]);

    // read of row 3 while row 3 completes: stalls through the completing pixel, accepted after
    bus.i_rd_valid = 1'b1;
    bus.i_rd_x     = 11'd1;
    bus.i_rd_y     = 11'd3;
    stream(4, 12, 4, 1'b1);
    #1;
    check("row3_ready", 32'(bus.o_rd_ready), 32'd1);
    tick();
    bus.i_rd_valid = 1'b0;
    check("row3_lb_valid", 32'(bus.o_lb_valid), 32'd1);
    check("row3_lb_bank", 32'(bus.o_lb_bank), 32'd3);
    check("row3_lb_addr", 32'(bus.o_lb_addr), 32'd1);
    check("row3_lb_miss", 32'(bus.o_lb_miss), 32'd0);

    stream(16, 16, 4, 1'b0);
    tick();
    check("done_state", 32'(o_dbg_state), 32'(LBS_DONE));
    i_wr_valid = 1'b1;
    tick();
    i_wr_valid = 1'b0;
    check("extra_row_drop", 32'(bus.o_wr_en), 32'd0);
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    check("end_state", 32'(o_dbg_state), 32'(LBS_IDLE));
    check("end_busy", 32'(o_busy), 32'd0);

    // frame B: 4x70 exercises bank wrap and eviction
    init_frame(4, 70, 2, 0);
    stream(280, 0, 4, 1'b0);
    for (int i = 0; i < 6; i++) apply_vec($sformatf("vecB%0d", i), vec_b[i]);
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;

    // frame C: timeout 5 with the writer stalled after 3 rows
    init_frame(4, 8, 2, 5);
    stream(12, 0, 4, 1'b0);
    bus.i_rd_valid = 1'b1;
    bus.i_rd_x     = 11'd0;
    bus.i_rd_y     = 11'd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("to_stall_c%0d", i), 32'(bus.o_rd_ready), 32'd0);
      tick();
      check($sformatf("to_nolb_c%0d", i), 32'(bus.o_lb_valid), 32'd0);
    end
    #1;
    check("to_force_ready", 32'(bus.o_rd_ready), 32'd1);
    tick();
    bus.i_rd_valid = 1'b0;
    check("to_lb_valid", 32'(bus.o_lb_valid), 32'd1);
    check("to_lb_miss", 32'(bus.o_lb_miss), 32'd1);

    // mid-RUN reset with a read and a write in flight
    bus.i_rd_valid = 1'b1;
    bus.i_rd_x     = 11'd2;
    bus.i_rd_y     = 11'd1;
    i_wr_valid     = 1'b1;
    i_rst          = 1'b1;
    tick();
    check("mid_rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("mid_rst_wr_bank", 32'(bus.o_wr_bank), 32'd0);
    check("mid_rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
    check("mid_rst_lb_valid", 32'(bus.o_lb_valid), 32'd0);
    check("mid_rst_lb_bank", 32'(bus.o_lb_bank), 32'd0);
    check("mid_rst_lb_addr", 32'(bus.o_lb_addr), 32'd0);
    check("mid_rst_lb_miss", 32'(bus.o_lb_miss), 32'd0);
    check("mid_rst_ready", 32'(bus.o_rd_ready), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_state", 32'(o_dbg_state), 32'(LBS_IDLE));
    i_rst          = 1'b0;
    bus.i_rd_valid = 1'b0;

    // restart: pixel coincident with frame start is row 0 col 0 in bank 0
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    check("restart_state", 32'(o_dbg_state), 32'(LBS_FILL));
    check("restart_wr_en", 32'(bus.o_wr_en), 32'd1);
    check("restart_wr_bank", 32'(bus.o_wr_bank), 32'd0);
    check("restart_wr_addr", 32'(bus.o_wr_addr), 32'd0);
    tick();
    i_wr_valid = 1'b0;
    check("restart_wr_addr1", 32'(bus.o_wr_addr), 32'd1);
    check("restart_wr_bank1", 32'(bus.o_wr_bank), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
